// File: rtl/hslip_pkg.sv
// Shared timing constants and types for the SLIPSTREAM horizontal timebase.
package hslip_pkg;
    typedef logic [8:0] hpos_t;

    localparam hpos_t HTOTAL_PAL   = 9'd384;
    localparam hpos_t HTOTAL_NTSC  = 9'd381;
    localparam hpos_t HBLANK_START = 9'd336;
    localparam hpos_t HBLANK_END   = 9'd48;
    localparam hpos_t HSYNC_START  = 9'd352;
    localparam hpos_t HSYNC_END    = 9'd380;
    localparam hpos_t START_RST    = 9'd64;
    localparam hpos_t END_RST      = 9'd320;
    localparam hpos_t INTPOS_RST   = 9'h1FF;
endpackage

// File: rtl/horizontal_timebase_if.sv
// CPU register bus of the horizontal timebase: write strobes, light-pen read strobes, read data.
interface horizontal_timebase_if;
    logic [7:0] WD;
    logic       HCNTL, HCNTH;
    logic       STARTL, STARTH;
    logic       ENDL, ENDH;
    logic       INTL, INTH;
    logic       LPRDL, LPRDH;
    logic [7:0] DOUT;
    logic       DOE;

    modport master (
        output WD, HCNTL, HCNTH, STARTL, STARTH, ENDL, ENDH, INTL, INTH, LPRDL, LPRDH,
        input  DOUT, DOE
    );
    modport slave (
        input  WD, HCNTL, HCNTH, STARTL, STARTH, ENDL, ENDH, INTL, INTH, LPRDL, LPRDH,
        output DOUT, DOE
    );
endinterface

// File: rtl/hslip_lpsync.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous light-pen trigger.
module hslip_lpsync (
    input  logic CLK,
    input  logic RES,
    input  logic LPCLK,
    output logic rise
);
    logic s1, s2, s3;

    always_ff @(posedge CLK) begin
        if (RES) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= LPCLK;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
endmodule

// File: rtl/horizontal_timebase.sv
// Horizontal pixel counter with line-region decodes, raster interrupt and light-pen latch.
module horizontal_timebase
    import hslip_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  HCLKEN,
    input  logic                  DIAG,
    input  logic                  NTSC,
    input  logic                  LPCLK,
    horizontal_timebase_if.slave  bus,
    output hpos_t                 HC,
    output logic                  HD1,
    output logic                  NEXTH,
    output logic                  HSYNC,
    output logic                  HBLANKING,
    output logic                  HBORDER,
    output logic                  HVACTIVE,
    output logic                  HINT
);
    hpos_t start_pos, end_pos, intpos, lp;
    hpos_t htotal_m1;
    logic  en, lp_rise;

    assign en        = (HCLKEN | DIAG) & ~RES;
    assign htotal_m1 = (NTSC ? HTOTAL_NTSC : HTOTAL_PAL) - 9'd1;

    // CPU writes take precedence over the count advance in the same cycle.
    always_ff @(posedge CLK) begin
        if (RES) begin
            HC <= '0;
        end else if (bus.HCNTL || bus.HCNTH) begin
            HC <= {bus.HCNTH ? bus.WD[0] : HC[8], bus.HCNTL ? bus.WD : HC[7:0]};
        end else if (en) begin
            HC <= (HC >= htotal_m1) ? 9'd0 : HC + 9'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            start_pos <= START_RST;
            end_pos   <= END_RST;
            intpos    <= INTPOS_RST;
        end else begin
            if (bus.STARTL) start_pos[7:0] <= bus.WD;
            if (bus.STARTH) start_pos[8]   <= bus.WD[0];
            if (bus.ENDL)   end_pos[7:0]   <= bus.WD;
            if (bus.ENDH)   end_pos[8]     <= bus.WD[0];
            if (bus.INTL)   intpos[7:0]    <= bus.WD;
            if (bus.INTH)   intpos[8]      <= bus.WD[0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) HINT <= 1'b0;
        else     HINT <= en && (HC == intpos);
    end

    hslip_lpsync u_lpsync (
        .CLK   (CLK),
        .RES   (RES),
        .LPCLK (LPCLK),
        .rise  (lp_rise)
    );

    always_ff @(posedge CLK) begin
        if (RES)          lp <= '0;
        else if (lp_rise) lp <= HC;
    end

    assign HD1       = en && (HC == 9'd1);
    assign NEXTH     = en && (HC == htotal_m1);
    assign HSYNC     = (HC >= HSYNC_START) && (HC < HSYNC_END);
    assign HBLANKING = (HC >= HBLANK_START) || (HC < HBLANK_END);
    assign HVACTIVE  = (HC >= start_pos) && (HC < end_pos);
    assign HBORDER   = ~HVACTIVE & ~HBLANKING;

    always_comb begin
        bus.DOUT = 8'h00;
        bus.DOE  = 1'b0;
        if (bus.LPRDL) begin
            bus.DOUT = lp[7:0];
            bus.DOE  = 1'b1;
        end else if (bus.LPRDH) begin
            bus.DOUT = {7'b0, lp[8]};
            bus.DOE  = 1'b1;
        end
    end
endmodule

// File: tb/tb_horizontal_timebase.sv
// Directed bench for horizontal_timebase: line timing, NTSC wrap, interrupt, window, light pen, reset.
module tb_horizontal_timebase;
    logic       CLK = 1'b0;
    logic       RES, HCLKEN, DIAG, NTSC, LPCLK;
    logic [8:0] HC;
    logic       HD1, NEXTH, HSYNC, HBLANKING, HBORDER, HVACTIVE, h_irq;
    int         n_cmp = 0;
    int         n_bad = 0;

    horizontal_timebase_if bus ();

    horizontal_timebase dut (
        .CLK(CLK), .RES(RES), .HCLKEN(HCLKEN), .DIAG(DIAG), .NTSC(NTSC), .LPCLK(LPCLK),
        .bus(bus), .HC(HC), .HD1(HD1), .NEXTH(NEXTH), .HSYNC(HSYNC),
        .HBLANKING(HBLANKING), .HBORDER(HBORDER), .HVACTIVE(HVACTIVE), .HINT(h_irq)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_hc(input int v);
        int k = 0;
        while (HC !== 9'(v) && k < 500) begin
            tick();
            k++;
        end
        chk("wait_hc", 32'(HC), 32'(v));
    endtask

    task automatic idle_bus();
        bus.WD = 8'h00;
        bus.HCNTL = 0; bus.HCNTH = 0; bus.STARTL = 0; bus.STARTH = 0;
        bus.ENDL = 0; bus.ENDH = 0; bus.INTL = 0; bus.INTH = 0;
        bus.LPRDL = 0; bus.LPRDH = 0;
    endtask

    initial begin
        int hs_cnt, hs_first, ub_cnt, ub_min, ub_max, nx_hc, h_cnt, h_hc;
        int a_cnt, a_min, a_max, b_cnt, b_min, b_max, k;

        idle_bus();
        RES = 1; HCLKEN = 0; DIAG = 0; NTSC = 0; LPCLK = 0;
        tick(); tick();
        HCLKEN = 1;
        chk("rst_hc", 32'(HC), 0);
        chk("rst_hd1_gated", 32'(HD1), 0);
        chk("rst_nexth_gated", 32'(NEXTH), 0);
        chk("rst_hint", 32'(h_irq), 0);
        chk("rst_doe", 32'(bus.DOE), 0);

        // 1: PAL free run
        RES = 0;
        tick();
        chk("first_hc", 32'(HC), 1);
        chk("hd1_at_1", 32'(HD1), 1);
        hs_cnt = 0; hs_first = -1; ub_cnt = 0; ub_min = 999; ub_max = -1; nx_hc = -1;
        for (int i = 1; i < 384; i++) begin
            if (HSYNC) begin
                if (hs_first < 0) hs_first = int'(HC);
                hs_cnt++;
            end
            if (!HBLANKING) begin
                ub_cnt++;
                if (int'(HC) < ub_min) ub_min = int'(HC);
                if (int'(HC) > ub_max) ub_max = int'(HC);
            end
            if (NEXTH) nx_hc = int'(HC);
            tick();
        end
        chk("pal_wrap_hc", 32'(HC), 0);
        chk("hsync_cnt", 32'(hs_cnt), 28);
        chk("hsync_first", 32'(hs_first), 352);
        chk("unblank_cnt", 32'(ub_cnt), 288);
        chk("unblank_min", 32'(ub_min), 48);
        chk("unblank_max", 32'(ub_max), 335);
        chk("pal_nexth_hc", 32'(nx_hc), 383);

        // 2: NTSC line length and mid-line switch
        NTSC = 1;
        k = 0;
        while (!NEXTH && k < 400) begin
            tick();
            k++;
        end
        chk("ntsc_nexth_hc", 32'(HC), 380);
        tick();
        chk("ntsc_wrap_hc", 32'(HC), 0);
        NTSC = 0;
        bus.WD = 8'h7E; bus.HCNTL = 1; tick(); bus.HCNTL = 0;
        bus.WD = 8'h01; bus.HCNTH = 1; tick(); bus.HCNTH = 0;
        chk("load_382", 32'(HC), 382);
        NTSC = 1;
        tick();
        chk("ntsc_flip_wrap", 32'(HC), 0);
        NTSC = 0;

        // 3: raster interrupt
        h_cnt = 0;
        for (int i = 0; i < 384; i++) begin
            if (h_irq) h_cnt++;
            tick();
        end
        chk("hint_disabled", 32'(h_cnt), 0);
        bus.WD = 8'h10; bus.INTL = 1; tick(); bus.INTL = 0;
        bus.WD = 8'h01; bus.INTH = 1; tick(); bus.INTH = 0;
        h_cnt = 0; h_hc = -1;
        for (int i = 0; i < 768; i++) begin
            if (h_irq) begin
                h_cnt++;
                h_hc = int'(HC);
            end
            tick();
        end
        chk("hint_cnt_2lines", 32'(h_cnt), 2);
        chk("hint_hc", 32'(h_hc), 273);

        // 4: display window 0x50..0x60
        bus.WD = 8'h50; bus.STARTL = 1; tick(); bus.STARTL = 0;
        bus.WD = 8'h60; bus.ENDL = 1; tick(); bus.ENDL = 0;
        bus.WD = 8'h00; bus.ENDH = 1; tick(); bus.ENDH = 0;
        wait_hc(0);
        a_cnt = 0; a_min = 999; a_max = -1; b_cnt = 0; b_min = 999; b_max = -1;
        for (int i = 0; i < 384; i++) begin
            if (HVACTIVE) begin
                a_cnt++;
                if (int'(HC) < a_min) a_min = int'(HC);
                if (int'(HC) > a_max) a_max = int'(HC);
            end
            if (HBORDER) begin
                b_cnt++;
                if (int'(HC) < b_min) b_min = int'(HC);
                if (int'(HC) > b_max) b_max = int'(HC);
            end
            tick();
        end
        chk("active_cnt", 32'(a_cnt), 16);
        chk("active_min", 32'(a_min), 80);
        chk("active_max", 32'(a_max), 95);
        chk("border_cnt", 32'(b_cnt), 272);
        chk("border_min", 32'(b_min), 48);
        chk("border_max", 32'(b_max), 335);

        // 5: light pen
        wait_hc(100);
        LPCLK = 1;
        tick(); tick(); tick(); tick();
        bus.LPRDL = 1; #1;
        chk("lprdl_dout", 32'(bus.DOUT), 32'h66);
        chk("lprdl_doe", 32'(bus.DOE), 1);
        bus.LPRDL = 0; bus.LPRDH = 1; #1;
        chk("lprdh_dout", 32'(bus.DOUT), 0);
        chk("lprdh_doe", 32'(bus.DOE), 1);
        bus.LPRDH = 0; #1;
        chk("idle_doe", 32'(bus.DOE), 0);
        chk("idle_dout", 32'(bus.DOUT), 0);
        LPCLK = 0;

        // 6: dual-byte load, out-of-range wrap, mid-line reset
        bus.WD = 8'hFF; bus.HCNTL = 1; bus.HCNTH = 1; tick();
        bus.HCNTL = 0; bus.HCNTH = 0;
        chk("load_1ff", 32'(HC), 32'h1FF);
        tick();
        chk("oor_wrap", 32'(HC), 0);
        wait_hc(200);
        RES = 1; #1;
        chk("res_hd1_low", 32'(HD1), 0);
        tick();
        chk("res_hc", 32'(HC), 0);
        chk("res_hint", 32'(h_irq), 0);
        bus.LPRDL = 1; #1;
        chk("res_lp", 32'(bus.DOUT), 0);
        bus.LPRDL = 0;
        RES = 0;
        a_cnt = 0; a_min = 999; h_cnt = 0;
        for (int i = 0; i < 384; i++) begin
            tick();
            if (HVACTIVE) begin
                a_cnt++;
                if (int'(HC) < a_min) a_min = int'(HC);
            end
            if (h_irq) h_cnt++;
        end
        chk("res_active_cnt", 32'(a_cnt), 256);
        chk("res_active_min", 32'(a_min), 64);
        chk("res_hint_off", 32'(h_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
